// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game-flow types and widths for the pong display path
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    MISS      = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int FRAME_TMR_W = 7;
  localparam int LIVES_W     = 2;

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable frame down-counter, expires on a tick at zero
module frame_timer
  import pong_pkg::*;
(
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   frame_tick,
  input  logic                   load,
  input  logic [FRAME_TMR_W-1:0] load_val,
  output logic                   expire
);

  logic [FRAME_TMR_W-1:0] count;

  // A load wins over a coincident tick, so the entry tick never counts.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (frame_tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = frame_tick && (count == '0);

endmodule

// File: rtl/lives_tracker.sv
// rtl/lives_tracker.sv - game-flow FSM owning the life count and the displayed lives
module lives_tracker
  import pong_pkg::*;
#(
  parameter logic [LIVES_W-1:0] START_LIVES  = 2'd3,
  parameter int                 SERVE_FRAMES = 60,
  parameter int                 MISS_FRAMES  = 90,
  parameter int                 BLINK_LOG2   = 3
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               ball_missed,
  output logic [LIVES_W-1:0] lives,
  output logic               ball_enable,
  output logic               serve,
  output logic               game_over
);

  localparam logic [FRAME_TMR_W-1:0] SERVE_LOAD = FRAME_TMR_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_TMR_W-1:0] MISS_LOAD  = FRAME_TMR_W'(MISS_FRAMES - 1);

  game_state_t            state, state_n;
  logic [LIVES_W-1:0]     life_cnt, life_n;
  logic [LIVES_W-1:0]     old_cnt, old_n;
  logic [BLINK_LOG2:0]    blink;
  logic                   tmr_load;
  logic [FRAME_TMR_W-1:0] tmr_val;
  logic                   tmr_expire;
  logic                   serve_n;

  frame_timer u_timer (
    .clk        (clk),
    .nRst       (nRst),
    .frame_tick (frame_tick),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .expire     (tmr_expire)
  );

  always_comb begin
    state_n  = state;
    life_n   = life_cnt;
    old_n    = old_cnt;
    tmr_load = 1'b0;
    tmr_val  = SERVE_LOAD;
    serve_n  = 1'b0;
    case (state)
      IDLE: begin
        life_n = START_LIVES;
        if (start) begin
          state_n  = SERVE;
          tmr_load = 1'b1;
        end
      end
      SERVE: begin
        if (tmr_expire) begin
          state_n = PLAY;
          serve_n = 1'b1;
        end
      end
      PLAY: begin
        if (ball_missed) begin
          old_n    = life_cnt;
          life_n   = life_cnt - 1'b1;
          tmr_load = 1'b1;
          tmr_val  = MISS_LOAD;
          state_n  = MISS;
        end
      end
      MISS: begin
        if (tmr_expire) begin
          if (life_cnt == '0) begin
            state_n = GAME_OVER;
          end else begin
            state_n  = SERVE;
            tmr_load = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          life_n   = START_LIVES;
          state_n  = SERVE;
          tmr_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      life_cnt    <= START_LIVES;
      old_cnt     <= START_LIVES;
      ball_enable <= 1'b0;
      serve       <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      life_cnt    <= life_n;
      old_cnt     <= old_n;
      ball_enable <= (state_n == PLAY);
      serve       <= serve_n;
      game_over   <= (state_n == GAME_OVER);
    end
  end

  // Display samples pre-edge state, so it only moves on a frame boundary.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lives <= START_LIVES;
      blink <= '0;
    end else if (frame_tick) begin
      lives <= ((state == MISS) && blink[BLINK_LOG2]) ? old_cnt : life_cnt;
      blink <= blink + 1'b1;
    end
  end

endmodule

// File: tb/tb_lives_tracker.sv
// tb/tb_lives_tracker.sv - self-checking bench for lives_tracker
module tb_lives_tracker;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       ball_missed = 1'b0;
  logic [1:0] lives;
  logic       ball_enable;
  logic       serve;
  logic       game_over;

  int vectors = 0;
  int miscompares = 0;

  lives_tracker dut (
    .clk         (clk),
    .nRst        (nRst),
    .frame_tick  (frame_tick),
    .start       (start),
    .ball_missed (ball_missed),
    .lives       (lives),
    .ball_enable (ball_enable),
    .serve       (serve),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Game model: phase name, frames left in the current timed phase, total ticks seen.
  string m_phase;
  int    m_life, m_before, m_left, m_ticks, m_lives;
  bit    m_serve;

  task automatic m_reset();
    m_phase = "idle";
    m_life = 3; m_before = 3; m_left = 0; m_ticks = 0; m_lives = 3; m_serve = 0;
  endtask

  task automatic m_step(input bit ft, input bit st, input bit bm);
    m_serve = 0;
    if (ft) begin
      m_lives = (m_phase == "miss" && ((m_ticks >> 3) & 1) == 1) ? m_before : m_life;
      m_ticks++;
    end
    if (m_phase == "idle") begin
      m_life = 3;
      if (st) begin m_phase = "serve"; m_left = 60; end
    end else if (m_phase == "serve") begin
      if (ft) begin
        m_left--;
        if (m_left == 0) begin m_phase = "play"; m_serve = 1; end
      end
    end else if (m_phase == "play") begin
      if (bm) begin
        m_before = m_life; m_life = m_life - 1; m_phase = "miss"; m_left = 90;
      end
    end else if (m_phase == "miss") begin
      if (ft) begin
        m_left--;
        if (m_left == 0) begin
          if (m_life == 0) m_phase = "over";
          else begin m_phase = "serve"; m_left = 60; end
        end
      end
    end else if (m_phase == "over") begin
      if (st) begin m_life = 3; m_phase = "serve"; m_left = 60; end
    end
  endtask

  always @(posedge clk or negedge nRst) begin
    if (!nRst) m_reset();
    else m_step(frame_tick, start, ball_missed);
    #1;
    check("lives", 32'(lives), 32'(m_lives));
    check("ball_enable", 32'(ball_enable), 32'(m_phase == "play"));
    check("serve", 32'(serve), 32'(m_serve));
    check("game_over", 32'(game_over), 32'(m_phase == "over"));
  end

  task automatic step(input bit ft, input bit st, input bit bm);
    frame_tick = ft; start = st; ball_missed = bm;
    @(posedge clk);
    #2;
    frame_tick = 1'b0; start = 1'b0; ball_missed = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  bit saw2, saw3;

  initial begin
    step(0, 0, 0);
    step(0, 0, 0);
    nRst = 1'b1;
    check("reset_lives", 32'(lives), 3);
    check("reset_ben", 32'(ball_enable), 0);
    check("reset_go", 32'(game_over), 0);
    check("reset_serve", 32'(serve), 0);

    ticks(3);
    step(0, 0, 1);
    check("idle_lives", 32'(lives), 3);
    check("idle_ben", 32'(ball_enable), 0);

    step(0, 1, 0);
    step(0, 0, 1);
    ticks(59);
    check("serve_wait_ben", 32'(ball_enable), 0);
    step(1, 0, 0);
    check("serve_pulse", 32'(serve), 1);
    check("serve_ben", 32'(ball_enable), 1);
    step(0, 0, 0);
    check("serve_done", 32'(serve), 0);

    step(0, 0, 1);
    check("miss_ben", 32'(ball_enable), 0);
    saw2 = 0; saw3 = 0;
    repeat (90) begin
      ticks(1);
      if (lives == 2'd2) saw2 = 1;
      if (lives == 2'd3) saw3 = 1;
    end
    check("miss_blink_both", 32'(saw2 && saw3), 1);
    ticks(1);
    check("after_miss_lives", 32'(lives), 2);
    check("after_miss_ben", 32'(ball_enable), 0);
    ticks(59);
    check("replay_ben", 32'(ball_enable), 1);

    step(1, 0, 1);
    check("coincident_tmr", 32'(dut.u_timer.count), 89);
    check("coincident_ben", 32'(ball_enable), 0);
    ticks(90);
    ticks(60);
    step(0, 0, 1);
    ticks(90);
    ticks(1);
    check("over_go", 32'(game_over), 1);
    check("over_lives", 32'(lives), 0);
    ticks(20);
    check("over_hold_go", 32'(game_over), 1);
    check("over_hold_lives", 32'(lives), 0);

    step(0, 1, 0);
    check("restart_go", 32'(game_over), 0);
    ticks(1);
    check("restart_lives", 32'(lives), 3);
    ticks(59);
    check("restart_play", 32'(ball_enable), 1);

    step(0, 0, 1);
    ticks(5);
    @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    check("async_lives", 32'(lives), 3);
    check("async_ben", 32'(ball_enable), 0);
    check("async_go", 32'(game_over), 0);
    check("async_serve", 32'(serve), 0);
    check("async_tmr", 32'(dut.u_timer.count), 0);
    @(negedge clk);
    nRst = 1'b1;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
